// File: rtl/mha_pingpong_reader.sv
`default_nettype none
// ============================================================================
// mha_pingpong_reader : two-bank tile store; full-word writes, per-module
// slice reads. Optional macro PINGPONG_OVERRUN_DET_EN adds overrun detection.
// Revision: 1.0
// ============================================================================
module mha_pingpong_reader #(
  parameter  int WIDTH         = 16,
  parameter  int BLOCK_SIZE    = 2,
  parameter  int TOTAL_MODULES = 4,
  parameter  int DEPTH         = 4,
  localparam int SLICE_W       = WIDTH * BLOCK_SIZE * BLOCK_SIZE,
  localparam int WORD_W        = SLICE_W * TOTAL_MODULES,
  localparam int MOD_W         = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1,
  localparam int ADDR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_data,
  output logic [MOD_W-1:0]   out_module,
  output logic               out_last,
  output logic               out_bank,
  output logic [1:0]         bank_full
`ifdef PINGPONG_OVERRUN_DET_EN
  ,
  output logic               overrun,
  output logic               overrun_pulse
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [MOD_W-1:0]  MOD_LAST  = MOD_W'(TOTAL_MODULES - 1);

  logic [WORD_W-1:0] mem_q [2][DEPTH];

  logic              wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              rd_sel_q, rd_sel_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [MOD_W-1:0]  mod_q, mod_d;
  logic [1:0]        bank_full_q, bank_full_d;

  logic              wr_fire;
  logic              wr_last;
  logic              rd_fire;
  logic [WORD_W-1:0] rd_word;

  assign in_ready   = ~bank_full_q[wr_sel_q];
  assign out_valid  = bank_full_q[rd_sel_q];
  assign wr_fire    = in_valid & in_ready;
  assign wr_last    = (wr_addr_q == ADDR_LAST);
  assign rd_fire    = out_valid & out_ready;

  assign rd_word    = mem_q[rd_sel_q][rd_addr_q];
  assign out_data   = rd_word[mod_q*SLICE_W +: SLICE_W];
  assign out_module = mod_q;
  assign out_bank   = rd_sel_q;
  assign out_last   = (rd_addr_q == ADDR_LAST) && (mod_q == MOD_LAST);
  assign bank_full  = bank_full_q;

  // Set and clear of the full flags always hit different banks, so both
  // may be applied in the same cycle without priority.
  always_comb begin
    wr_sel_d    = wr_sel_q;
    wr_addr_d   = wr_addr_q;
    rd_sel_d    = rd_sel_q;
    rd_addr_d   = rd_addr_q;
    mod_d       = mod_q;
    bank_full_d = bank_full_q;

    if (wr_fire) begin
      if (wr_last) begin
        wr_addr_d             = '0;
        wr_sel_d              = ~wr_sel_q;
        bank_full_d[wr_sel_q] = 1'b1;
      end else begin
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end

    if (rd_fire) begin
      if (out_last) begin
        bank_full_d[rd_sel_q] = 1'b0;
        rd_sel_d              = ~rd_sel_q;
        rd_addr_d             = '0;
        mod_d                 = '0;
      end else if (mod_q == MOD_LAST) begin
        mod_d     = '0;
        rd_addr_d = rd_addr_q + 1'b1;
      end else begin
        mod_d = mod_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel_q    <= 1'b0;
      wr_addr_q   <= '0;
      rd_sel_q    <= 1'b0;
      rd_addr_q   <= '0;
      mod_q       <= '0;
      bank_full_q <= 2'b00;
    end else begin
      wr_sel_q    <= wr_sel_d;
      wr_addr_q   <= wr_addr_d;
      rd_sel_q    <= rd_sel_d;
      rd_addr_q   <= rd_addr_d;
      mod_q       <= mod_d;
      bank_full_q <= bank_full_d;
    end
  end

  // Storage has no reset; a bank is only exposed once fully rewritten.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_sel_q][wr_addr_q] <= in_data;
    end
  end

`ifdef PINGPONG_OVERRUN_DET_EN
  logic overrun_q, overrun_d;
  logic overrun_pulse_q, overrun_pulse_d;

  always_comb begin
    overrun_pulse_d = in_valid & ~in_ready;
    overrun_d       = overrun_q | overrun_pulse_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q       <= 1'b0;
      overrun_pulse_q <= 1'b0;
    end else begin
      overrun_q       <= overrun_d;
      overrun_pulse_q <= overrun_pulse_d;
    end
  end

  assign overrun       = overrun_q;
  assign overrun_pulse = overrun_pulse_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mha_pingpong_reader.sv
`default_nettype none
// ============================================================================
// tb_mha_pingpong_reader : randomized phases checked against a bank-queue
// reference model. Revision: 1.0
// ============================================================================
module tb_mha_pingpong_reader;

  localparam int SLICE_W = 64;
  localparam int WORD_W  = 256;
  localparam int TM      = 4;
  localparam int DEPTH   = 4;
  localparam int BEATS   = DEPTH * TM;
  localparam int NPH     = 9;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [SLICE_W-1:0] out_data;
  logic [1:0]         out_module;
  logic               out_last;
  logic               out_bank;
  logic [1:0]         bank_full;
`ifdef PINGPONG_OVERRUN_DET_EN
  logic               overrun;
  logic               overrun_pulse;
`endif

  mha_pingpong_reader dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_module   (out_module),
    .out_last     (out_last),
    .out_bank     (out_bank),
    .bank_full    (bank_full)
`ifdef PINGPONG_OVERRUN_DET_EN
    ,
    .overrun      (overrun),
    .overrun_pulse(overrun_pulse)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: completed banks form a FIFO of whole words; the reader
  // walks a beat index 0..15 over the front bank.
  int                m_nfull  = 0;
  int                m_rdbank = 0;
  int                m_beat   = 0;
  logic [WORD_W-1:0] m_part[$];
  logic [WORD_W-1:0] m_full[$];
  bit                m_ovr    = 0;
  bit                m_pulse  = 0;

  task automatic check_outputs();
    logic [WORD_W-1:0] w;
    logic [1:0]        exp_bf;
    if (m_nfull == 0)      exp_bf = 2'b00;
    else if (m_nfull == 1) exp_bf = (m_rdbank == 1) ? 2'b10 : 2'b01;
    else                   exp_bf = 2'b11;
    check("in_ready",   64'(in_ready),   64'(m_nfull < 2));
    check("out_valid",  64'(out_valid),  64'(m_nfull > 0));
    check("bank_full",  64'(bank_full),  64'(exp_bf));
    check("out_bank",   64'(out_bank),   64'(m_rdbank));
    check("out_module", 64'(out_module), 64'(m_beat % TM));
    check("out_last",   64'(out_last),   64'(m_beat == BEATS - 1));
    if (m_nfull > 0) begin
      w = m_full[m_beat / TM];
      check("out_data", out_data, w[(m_beat % TM)*SLICE_W +: SLICE_W]);
    end
`ifdef PINGPONG_OVERRUN_DET_EN
    check("overrun",       64'(overrun),       64'(m_ovr));
    check("overrun_pulse", 64'(overrun_pulse), 64'(m_pulse));
`endif
  endtask

  task automatic model_step();
    bit rfire, wfire, ovr_ev;
    if (rst) begin
      m_nfull = 0; m_rdbank = 0; m_beat = 0;
      m_part.delete(); m_full.delete();
      m_ovr = 0; m_pulse = 0;
    end else begin
      rfire  = (m_nfull > 0) && out_ready;
      wfire  = in_valid && (m_nfull < 2);
      ovr_ev = in_valid && (m_nfull >= 2);
      m_ovr   = m_ovr | ovr_ev;
      m_pulse = ovr_ev;
      if (rfire) begin
        m_beat++;
        if (m_beat == BEATS) begin
          m_beat = 0;
          repeat (DEPTH) void'(m_full.pop_front());
          m_nfull--;
          m_rdbank ^= 1;
        end
      end
      if (wfire) begin
        m_part.push_back(in_data);
        if (m_part.size() == DEPTH) begin
          foreach (m_part[i]) m_full.push_back(m_part[i]);
          m_part.delete();
          m_nfull++;
        end
      end
    end
  endtask

  // Phase table: write-valid %, read-ready %, length, addr/module data pattern,
  // cycle within the phase at which reset pulses (-1: none).
  int pv  [NPH] = '{100, 100,  50,   0, 100,  70,  30,  90, 100};
  int pr  [NPH] = '{100,   0,  50, 100, 100,  60, 100,  30, 100};
  int len [NPH] = '{ 40,  20,  60,  30,  40, 200, 200, 200,  50};
  int pat [NPH] = '{  1,   1,   0,   0,   0,   0,   0,   0,   1};
  int rstc[NPH] = '{ -1,  -1,  -1,  -1,  -1,  15,  -1, 100,  -1};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);

    for (int p = 0; p < NPH; p++) begin
      for (int c = 0; c < len[p]; c++) begin
        @(negedge clk);
        check_outputs();
        rst       = (c == rstc[p]);
        in_valid  = ($urandom_range(99) < pv[p]);
        out_ready = ($urandom_range(99) < pr[p]);
        for (int m = 0; m < TM; m++) begin
          if (pat[p] != 0) in_data[m*SLICE_W +: SLICE_W] = 64'(m_part.size()*16 + m);
          else             in_data[m*SLICE_W +: SLICE_W] = {$urandom, $urandom};
        end
        model_step();
      end
    end

    @(negedge clk);
    check_outputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
